// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: registered N:1 stream multiplexer with per-channel
// valid/ready. A channel is chosen either by an explicit select or by a
// round-robin search starting at rr_q. The chosen word lands in a single
// output register that can be refilled in the same cycle it drains.

module mux_n_1_stream #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]       in_valid_i,
    output logic [NUM_IN-1:0]       in_ready_o,
    input  logic [SELW-1:0]         sel_i,
    input  logic                    mode_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SELW-1:0]         out_sel_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    // Channel count and last index at the widths used for comparisons.
    localparam logic [SELW:0]   NUM_IN_L = (SELW+1)'(NUM_IN);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_IN - 1);

    // Output pipeline register and round-robin pointer.
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SELW-1:0]   out_sel_q,   out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [SELW-1:0]   rr_q,        rr_d;

    // Combinational grant and datapath signals.
    logic              can_load_s;
    logic              grant_vld_s;
    logic [SELW-1:0]   grant_idx_s;
    logic [NUM_IN-1:0] grant_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic              xfer_s;

    // The output slot may accept a word when empty or when it drains this cycle.
    always_comb begin
        can_load_s = 1'b0;
        if (!out_valid_q || out_ready_i) begin
            can_load_s = 1'b1;
        end else begin
            can_load_s = 1'b0;
        end
    end

    // Pick the grantable channel: explicit select or round-robin from rr_q.
    always_comb begin
        logic [SELW:0] cand_v;
        logic          found_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_v      = '0;
        found_v     = 1'b0;
        if (mode_i == 1'b0) begin
            // Out-of-range selects (non-power-of-2 NUM_IN) never grant.
            if ({1'b0, sel_i} < NUM_IN_L) begin
                if (in_valid_i[sel_i]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = sel_i;
                end else begin
                    grant_vld_s = 1'b0;
                end
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            // rr_q < NUM_IN, so one conditional subtraction wraps the candidate.
            for (int i = 0; i < NUM_IN; i++) begin
                cand_v = {1'b0, rr_q} + (SELW+1)'(i);
                if (cand_v >= NUM_IN_L) begin
                    cand_v = cand_v - NUM_IN_L;
                end else begin
                    cand_v = cand_v;
                end
                if (!found_v && in_valid_i[cand_v[SELW-1:0]]) begin
                    found_v     = 1'b1;
                    grant_idx_s = cand_v[SELW-1:0];
                end else begin
                    found_v = found_v;
                end
            end
            grant_vld_s = found_v;
        end
    end

    // Expand the granted index into a one-hot (or all-zero) vector.
    always_comb begin
        grant_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_vld_s && (grant_idx_s == SELW'(k))) begin
                grant_s[k] = 1'b1;
            end else begin
                grant_s[k] = 1'b0;
            end
        end
    end

    // AND-OR selection of the granted channel's data.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_s[k]) begin
                sel_data_s = sel_data_s | in_data_i[k*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Ready goes to the granted channel only, and never while in reset.
    always_comb begin
        in_ready_o = '0;
        if (rst_ni && can_load_s) begin
            in_ready_o = grant_s;
        end else begin
            in_ready_o = '0;
        end
    end

    // A transfer happens when the granted channel is valid and the slot is free.
    always_comb begin
        xfer_s = 1'b0;
        if (grant_vld_s && can_load_s) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Next-state for the output register: load wins over drain, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_sel_d   = grant_idx_s;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Round-robin pointer moves past the winner only on round-robin transfers.
    always_comb begin
        rr_d = rr_q;
        if (xfer_s && mode_i) begin
            if (grant_idx_s == LAST_IDX) begin
                rr_d = '0;
            end else begin
                rr_d = grant_idx_s + SELW'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_q        <= rr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

    mux_n_1_stream_chk #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SELW   (SELW)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_i  (in_ready_o),
        .out_data_i  (out_data_q),
        .out_sel_i   (out_sel_q),
        .out_valid_i (out_valid_q),
        .out_ready_i (out_ready_i)
    );

endmodule

// Protocol properties of the stream mux; carries no logic of its own.
module mux_n_1_stream_chk #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SELW   = $clog2(NUM_IN)
) (
    input logic              clk_i,
    input logic              rst_ni,
    input logic [NUM_IN-1:0] in_valid_i,
    input logic [NUM_IN-1:0] in_ready_i,
    input logic [WIDTH-1:0]  out_data_i,
    input logic [SELW-1:0]   out_sel_i,
    input logic              out_valid_i,
    input logic              out_ready_i
);

    // At most one channel is offered ready at a time.
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(in_ready_i));

    // Ready is only ever offered to a channel that is presenting valid.
    a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_ready_i & ~in_valid_i) == '0);

    // A stalled output blocks every input.
    a_stall_blocks: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_i && !out_ready_i) |-> (in_ready_i == '0));

    // A stalled output word stays put until accepted.
    a_stall_holds: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_i && !out_ready_i) |=>
            (out_valid_i && $stable(out_data_i) && $stable(out_sel_i)));

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Scoreboard bench for mux_n_1_stream: stimulus pushes hand-computed
// expected words; a negedge monitor pops and compares on each drain.
module tb_mux_n_1_stream;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int W3 = 8;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [1:0]      sel;
    logic            mode;
    logic [W-1:0]    out_data;
    logic [1:0]      out_sel;
    logic            out_valid;
    logic            out_ready;

    logic [N3*W3-1:0] in_data3;
    logic [N3-1:0]    in_valid3;
    logic [N3-1:0]    in_ready3;
    logic [1:0]       sel3;
    logic             mode3;
    logic [W3-1:0]    out_data3;
    logic [1:0]       out_sel3;
    logic             out_valid3;
    logic             out_ready3;

    mux_n_1_stream #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .sel_i(sel), .mode_i(mode), .out_data_o(out_data),
        .out_sel_o(out_sel), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    mux_n_1_stream #(.WIDTH(W3), .NUM_IN(N3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data3), .in_valid_i(in_valid3),
        .in_ready_o(in_ready3), .sel_i(sel3), .mode_i(mode3), .out_data_o(out_data3),
        .out_sel_o(out_sel3), .out_valid_o(out_valid3), .out_ready_i(out_ready3)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive, check ready, queue the expected word.
    task automatic step(input logic [3:0] vld, input logic [1:0] s, input logic md,
                        input logic rdy, input logic [3:0] exp_rdy, input logic push,
                        input logic [31:0] exp_d, input logic [1:0] exp_s, input string name);
        @(posedge clk);
        #1;
        in_valid  = vld;
        sel       = s;
        mode      = md;
        out_ready = rdy;
        #3;
        check({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (push) q.push_back('{exp_d, exp_s});
    endtask

    // Monitor: every accepted output word must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data 0x%0h sel %0d, expected none", out_data, out_sel);
                end else begin
                    mon_e = q.pop_front();
                    check("mon out_data", out_data, mon_e.d);
                    check("mon out_sel", 32'(out_sel), 32'(mon_e.s));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
        in_valid  = 4'hF;
        sel       = 2'd0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_data3  = {8'h33, 8'h22, 8'h11};
        in_valid3 = 3'b000;
        sel3      = 2'd0;
        mode3     = 1'b0;
        out_ready3 = 1'b1;

        // Reset state
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_sel", 32'(out_sel), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        in_valid = 4'h0;
        rst_n    = 1'b1;

        // Explicit select 0..3
        for (int k = 0; k < 4; k++) begin
            step(4'hF, 2'(k), 1'b0, 1'b1, 4'(4'b0001 << k), 1'b1, 32'(k + 1), 2'(k), "explicit");
        end

        // Round-robin fairness with all channels valid
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 2'd0, 1'b1, 1'b1, 4'(4'b0001 << (i % 4)), 1'b1, 32'((i % 4) + 1), 2'(i % 4), "rr_fair");
        end

        // Sparse round-robin with wrap: pointer to 3, then valids 0101
        step(4'b0100, 2'd0, 1'b1, 1'b1, 4'b0100, 1'b1, 32'd3, 2'd2, "rr_setup");
        step(4'b0101, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0, "rr_wrap0");
        step(4'b0101, 2'd0, 1'b1, 1'b1, 4'b0100, 1'b1, 32'd3, 2'd2, "rr_wrap2");
        step(4'b0101, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0, "rr_wrap0b");
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "idle");
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "idle");
        check("drained out_valid", 32'(out_valid), 32'd0);

        // Backpressure
        in_data = {32'd4, 32'h5A, 32'hA5, 32'd1};
        step(4'b0010, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 32'hA5, 2'd1, "bp_load");
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 32'd0, 2'd0, "bp_hold");
            check("bp_hold out_data", out_data, 32'hA5);
            check("bp_hold out_valid", 32'(out_valid), 32'd1);
        end
        step(4'b0100, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 32'h5A, 2'd2, "bp_release");
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "bp_after");
        check("no_bubble out_valid", 32'(out_valid), 32'd1);
        check("no_bubble out_data", out_data, 32'h5A);
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "idle");

        // Invalid select: channel 2 not valid
        step(4'b1011, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "bad_sel");
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "idle");
        check("bad_sel out_valid", 32'(out_valid), 32'd0);

        // NUM_IN=3 instance: out-of-range select, then select 2, then round-robin
        @(posedge clk); #1;
        in_valid3 = 3'b111; sel3 = 2'd3; mode3 = 1'b0;
        #3;
        check("n3 sel3 in_ready", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        sel3 = 2'd2;
        #3;
        check("n3 sel3 no_xfer", 32'(out_valid3), 32'd0);
        check("n3 sel2 in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk); #1;
        mode3 = 1'b1;
        #3;
        check("n3 sel2 out_data", 32'(out_data3), 32'h33);
        check("n3 sel2 out_sel", 32'(out_sel3), 32'd2);
        check("n3 rr0 in_ready", 32'(in_ready3), 32'b001);
        @(posedge clk); #4;
        check("n3 rr1 in_ready", 32'(in_ready3), 32'b010);
        @(posedge clk); #4;
        check("n3 rr2 in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk); #4;
        check("n3 rr_wrap in_ready", 32'(in_ready3), 32'b001);
        in_valid3 = 3'b000;

        // Async reset mid-stream with a held word and pointer at 2
        in_data = {32'd4, 32'd3, 32'd2, 32'd1};
        step(4'b0010, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 32'd2, 2'd1, "rr_pre");
        step(4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'd0, 2'd0, "hold");
        check("pre_rst out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst out_valid", 32'(out_valid), 32'd0);
        check("async_rst out_data", out_data, 32'd0);
        check("async_rst out_sel", 32'(out_sel), 32'd0);
        q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        step(4'hF, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0, "rr_after_rst");
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "idle");
        step(4'b0000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, "idle");
        check("scoreboard empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_1_stream.md
Name: mux_n_1_stream

Overview:
- Parametrised, registered N:1 multiplexer with per-channel valid/ready handshake. Successor to the combinational 4:1 select mux.
- Selects one of NUM_IN WIDTH-bit input channels in one of two ways: explicit select (mode_i=0) or round-robin arbitration (mode_i=1).
- Holds the chosen word in a single output pipeline register. Used on core datapaths where sources are decoupled by backpressure, e.g. writeback and LSU-response merging.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels (2..16).
- SELW, $clog2(NUM_IN), select/index width (derived; do not override).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- in_data_i  input  NUM_IN*WIDTH  packed input data; channel k at bits [k*WIDTH +: WIDTH].
- in_valid_i  input  NUM_IN  per-channel valid.
- in_ready_o  output  NUM_IN  per-channel ready; combinational.
- sel_i  input  SELW  channel select, used when mode_i=0.
- mode_i  input  1  0 = explicit select, 1 = round-robin.
- out_data_o  output  WIDTH  registered selected data.
- out_sel_o  output  SELW  registered index of the channel that supplied out_data_o.
- out_valid_o  output  1  output register holds a word.
- out_ready_i  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_ni=0, async): out_valid_o=0, out_data_o=0, out_sel_o=0, round-robin pointer rr_q=0. in_ready_o is 0 while in reset.
- Slot free: can_load = !out_valid_o || out_ready_i (register empty, or draining this cycle).
- Grant (combinational, one-hot or zero):
  - mode_i=0: grant channel sel_i if sel_i < NUM_IN and in_valid_i[sel_i]=1. If sel_i >= NUM_IN, no grant.
  - mode_i=1: grant the first k with in_valid_i[k]=1, searching rr_q, rr_q+1, ... NUM_IN-1, 0, ... rr_q-1 (modulo wrap).
- Ready: in_ready_o[k] = can_load && (k is the grantable channel). At most one bit is high. Ready never depends on anything other than grant and can_load; valid-only sources see ready=0.
- Transfer on channel k: in_valid_i[k] && in_ready_o[k]. At the next edge, out_data_o <= channel k data, out_sel_o <= k, out_valid_o <= 1.
- Latency: 1 cycle from input transfer to out_valid_o.
- Throughput: 1 word/cycle when out_ready_i is held high.
- Output drains (out_valid_o && out_ready_i) with no new transfer: out_valid_o <= 0. out_data_o and out_sel_o hold their last value.
- Simultaneous drain and load in the same cycle: the new word replaces the old; out_valid_o stays 1. No bubble, no loss.
- Backpressure: while out_valid_o=1 and out_ready_i=0, out_data_o and out_sel_o are stable, and all in_ready_o=0.
- Round-robin pointer:
  - Updates only on a transfer made in mode_i=1: rr_q <= (k+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
  - Unchanged in mode_i=0.
  - Unchanged on cycles with no transfer.
- Mode or select change: takes effect combinationally on the next grant evaluation. A word already in the output register is unaffected.
- Reset mid-operation: a pending output word is discarded (out_valid_o drops immediately and asynchronously) and rr_q returns to 0.
- Arithmetic: pointer increment is SELW-bit with an explicit wrap at NUM_IN, so non-power-of-2 NUM_IN (e.g. 3) works.

Test Plan:
- Explicit select: NUM_IN=4, channel data 1,2,3,4, all valids=1, out_ready_i=1, mode_i=0. Step sel_i 0,1,2,3 on successive cycles -> out_data_o 1,2,3,4 one cycle later each; out_sel_o 0,1,2,3; in_ready_o one-hot 0001,0010,0100,1000.
- Round-robin fairness: mode_i=1, all 4 valids held=1, out_ready_i=1 for 8 cycles -> out_sel_o sequence 0,1,2,3,0,1,2,3 and data 1,2,3,4,1,2,3,4.
- Sparse round-robin with wrap: mode_i=1, rr_q=3, valids=0101 -> grant channel 0 (wrap past 3). Next cycle grant 2, then 0.
- Backpressure: load data 0xA5 from channel 1, then hold out_ready_i=0 for 5 cycles with channel 2 valid -> out_data_o stays 0xA5, out_valid_o=1, in_ready_o=0000. Release -> 0xA5 drains and channel 2 data loads in the same edge, no bubble.
- Invalid select and idle: mode_i=0, sel_i=2, in_valid_i[2]=0 -> in_ready_o=0000, out_valid_o falls after drain. NUM_IN=3 instance with sel_i=3 -> no grant, no transfer.
- Async reset mid-stream: assert rst_ni=0 between clock edges while out_valid_o=1 and rr_q=2 -> out_valid_o=0, out_data_o=0 immediately. After release, the round-robin grant starts at channel 0.
